fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch sequencer that owns the architectural PC register and drives the instruction-memory request/acknowledge handshake. It launches one fetch per instruction, presents the fetched word and its PC to the datapath, and advances to the next-PC value produced by the next-PC unit once the datapath retires the instruction. It also applies pipeline stalls, enforces fetch-address alignment and bounds memory latency with a timeout. It sits between the next-PC logic and the instruction memory, replacing a free-running PC register.

## Interface
- RESET_PC, default 32'h0000_0000: PC loaded on reset; first fetch address.
- TIMEOUT_CYC, default 255: maximum consecutive unacknowledged request cycles; legal range 1..65535.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- npc  in  32  next PC from the next-PC unit.
- npc_valid  in  1  datapath has completed the current instruction; npc is valid this cycle.
- stall  in  1  hazard hold; blocks the PC update.
- ifetch_req  out  1  instruction-memory request.
- ifetch_addr  out  32  fetch address; equals pc.
- ifetch_ack  in  1  memory accepts the request and returns data in the same cycle.
- ifetch_data  in  32  fetched instruction word; valid when ifetch_ack=1.
- pc  out  32  PC of the instruction currently held.
- inst  out  32  held instruction word.
- inst_valid  out  1  inst/pc are valid for execution.
- fetch_err  out  1  sticky error flag (timeout or misaligned npc).

## Operation
- States: RST, FETCH, EXEC, ERROR. All outputs are registered.
- Reset (rst_n=0 at a rising edge), regardless of current state:
  - state=RST, pc=RESET_PC, inst=0.
  - ifetch_req=0, inst_valid=0, fetch_err=0, wait counter=0.
- RST: unconditionally goes to FETCH on the next edge and sets ifetch_req=1.
- FETCH:
  - ifetch_req=1, ifetch_addr=pc, both held stable until acknowledged.
  - On ifetch_ack=1: inst<=ifetch_data, inst_valid<=1, ifetch_req<=0, counter<=0, go to EXEC.
  - Otherwise counter increments by 1. Counter width is clog2(TIMEOUT_CYC+1) and it never wraps.
  - When counter reaches TIMEOUT_CYC-1 and ack is still 0: go to ERROR, ifetch_req<=0, fetch_err<=1.
- EXEC:
  - inst_valid=1.
  - If npc_valid=1 and stall=0 and npc[1:0]=0: pc<=npc, inst_valid<=0, ifetch_req<=1, go to FETCH.
  - If stall=1: hold all state. npc_valid is ignored; the datapath must re-present it after the stall.
  - If npc_valid=1, stall=0 and npc[1:0]!=0: pc<=npc (kept for debug), inst_valid<=0, fetch_err<=1, go to ERROR.
- ERROR: terminal until reset. ifetch_req=0, inst_valid=0, fetch_err=1, pc frozen.
- ifetch_ack outside FETCH is ignored.
- stall has no effect in FETCH, RST or ERROR.

## Timing
- First request: ifetch_req rises at the first edge after rst_n returns high, with ifetch_addr=RESET_PC.
- Fetch latency:
  - Ack sampled at edge k gives inst_valid=1 after edge k.
  - Zero-wait memory (ack in the first req cycle): request at cycle n, inst_valid at cycle n+1.
- Redirect: npc_valid at edge m gives pc=npc and ifetch_req=1 after edge m. Peak throughput is one instruction per 2 cycles.
- Timeout: with ack held 0, ERROR is entered at the edge ending the TIMEOUT_CYC-th request cycle.
  - Ack in that same cycle wins: the fetch completes normally.
  - TIMEOUT_CYC=1 means only a same-cycle ack succeeds.
- Reset mid-fetch: ifetch_req drops at the reset edge. Any outstanding ack is discarded.

## Test plan
- Reset release with RESET_PC=32'h0000_1000 and ack tied to 1:
  - Next cycle: req=1, addr=32'h0000_1000.
  - Following cycle: inst_valid=1, inst=ifetch_data, req=0.
- 3-cycle memory latency (ack on the 3rd req cycle), then npc=32'h0000_1004 with npc_valid=1:
  - addr stable for 3 cycles; inst_valid one cycle after ack.
  - pc=32'h0000_1004 and req=1 one cycle after npc_valid.
- stall=1 for 4 cycles in EXEC with npc_valid=1 throughout:
  - pc, inst and inst_valid unchanged during the stall.
  - Redirect occurs only on the first cycle with stall=0.
- TIMEOUT_CYC=8, ack never asserted: req high exactly 8 cycles, then req=0 and fetch_err=1. A late ack is ignored.
- npc=32'h0000_1006 with npc_valid=1: fetch_err=1, pc=32'h0000_1006, no further requests until reset.
- rst_n low during the 2nd wait cycle of a fetch:
  - All outputs return to reset values.
  - A fresh request at RESET_PC follows release.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Fetch sequencer. Owns the architectural PC, issues one
//                instruction-memory request per instruction, holds the
//                fetched word for the datapath, and advances to the next-PC
//                value once the datapath retires the instruction. Applies
//                stalls, checks next-PC alignment and bounds memory latency
//                with a timeout.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC      PC loaded on reset; address of the first fetch
//    TIMEOUT_CYC   max consecutive unacknowledged request cycles (1..65535)
//  Ports
//    clk_i          system clock, rising edge
//    rst_ni         synchronous active-low reset
//    npc_i          next PC from the next-PC unit
//    npc_valid_i    current instruction retired, npc_i valid
//    stall_i        hazard hold, blocks the PC update
//    ifetch_req_o   instruction-memory request
//    ifetch_addr_o  fetch address (equals pc_o)
//    ifetch_ack_i   memory accepts request, data returned same cycle
//    ifetch_data_i  fetched instruction word, valid with ifetch_ack_i
//    pc_o           PC of the instruction currently held
//    inst_o         held instruction word
//    inst_valid_o   inst_o / pc_o valid for execution
//    fetch_err_o    sticky error (timeout or misaligned next PC)
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] npc_i,
    input  logic        npc_valid_i,
    input  logic        stall_i,
    output logic        ifetch_req_o,
    output logic [31:0] ifetch_addr_o,
    input  logic        ifetch_ack_i,
    input  logic [31:0] ifetch_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        fetch_err_o
);

    // Wait counter sized to hold TIMEOUT_CYC; it never counts past
    // TIMEOUT_CYC-1 because that value ends the fetch.
    localparam int            CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    state_e             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        inst_q;
    logic               req_q;
    logic               inst_valid_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               npc_misaligned;
    logic               retire;

    assign cnt_d          = cnt_q + 1'b1;
    assign npc_misaligned = |npc_i[1:0];
    // Stall takes priority: a retire presented during a stall is dropped and
    // must be re-presented by the datapath afterwards.
    assign retire         = npc_valid_i & ~stall_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_RST;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            req_q        <= 1'b0;
            inst_valid_q <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_RST: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                    cnt_q   <= '0;
                end

                ST_FETCH: begin
                    // An ack in the final allowed cycle still completes the
                    // fetch, so the ack test comes before the timeout test.
                    if (ifetch_ack_i) begin
                        inst_q       <= ifetch_data_i;
                        inst_valid_q <= 1'b1;
                        req_q        <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= ST_EXEC;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_ERROR;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_EXEC: begin
                    if (retire) begin
                        // The next PC is captured even when misaligned so the
                        // offending address is visible for debug.
                        pc_q         <= npc_i;
                        inst_valid_q <= 1'b0;
                        if (npc_misaligned) begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERROR;
                        end else begin
                            req_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_FETCH;
                        end
                    end
                end

                ST_ERROR: begin
                    // Terminal until reset; outputs pinned to error values.
                    req_q        <= 1'b0;
                    inst_valid_q <= 1'b0;
                    err_q        <= 1'b1;
                end

                default: begin
                    state_q <= ST_RST;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ifetch_req_o  = req_q;
    assign ifetch_addr_o = pc_q;
    assign pc_o          = pc_q;
    assign inst_o        = inst_q;
    assign inst_valid_o  = inst_valid_q;
    assign fetch_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl. Directed stimulus pushes
//                expected requests, fetched instructions and error events
//                into queues; a negedge monitor pops and compares whenever
//                the DUT raises the matching output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] RPC = 32'h0000_1000;
    localparam int          TO  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic        npc_valid;
    logic        stall;
    logic        ack;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        iv;
    logic        err;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC    (RPC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .npc_i         (npc),
        .npc_valid_i   (npc_valid),
        .stall_i       (stall),
        .ifetch_req_o  (req),
        .ifetch_addr_o (addr),
        .ifetch_ack_i  (ack),
        .ifetch_data_i (data),
        .pc_o          (pc),
        .inst_o        (inst),
        .inst_valid_o  (iv),
        .fetch_err_o   (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_req_q [$];
    logic [63:0] exp_inst_q[$];
    logic [31:0] exp_err_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event with value %h expected no event", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares on rising edges of req / inst_valid / fetch_err.
    logic        p_req = 1'b0;
    logic        p_iv  = 1'b0;
    logic        p_err = 1'b0;
    logic [63:0] mon_e;
    logic [31:0] mon_w;

    always @(negedge clk) begin
        if (req && !p_req) begin
            if (exp_req_q.size() == 0) unexpected("unexpected_req", addr);
            else begin
                mon_w = exp_req_q.pop_front();
                chk("req_addr", addr, mon_w);
            end
        end
        if (iv && !p_iv) begin
            if (exp_inst_q.size() == 0) unexpected("unexpected_inst", inst);
            else begin
                mon_e = exp_inst_q.pop_front();
                chk("inst_pc", pc, mon_e[63:32]);
                chk("inst_word", inst, mon_e[31:0]);
            end
        end
        if (err && !p_err) begin
            if (exp_err_q.size() == 0) unexpected("unexpected_err", pc);
            else begin
                mon_w = exp_err_q.pop_front();
                chk("err_pc", pc, mon_w);
            end
        end
        p_req = req;
        p_iv  = iv;
        p_err = err;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rst_n = 1'b0; npc = '0; npc_valid = 1'b0; stall = 1'b0;
        ack = 1'b0; data = '0;
        step(); step();

        // Reset values
        chk("rst_req",  {31'b0, req}, 32'd0);
        chk("rst_iv",   {31'b0, iv},  32'd0);
        chk("rst_err",  {31'b0, err}, 32'd0);
        chk("rst_pc",   pc,   RPC);
        chk("rst_inst", inst, 32'd0);

        // Reset release with ack tied high
        ack = 1'b1; data = 32'hDEAD_0001;
        exp_req_q.push_back(RPC);
        exp_inst_q.push_back({RPC, 32'hDEAD_0001});
        rst_n = 1'b1;
        step();
        chk("t1_req",  {31'b0, req}, 32'd1);
        chk("t1_addr", addr, RPC);
        step();
        chk("t1_iv",   {31'b0, iv},  32'd1);
        chk("t1_inst", inst, 32'hDEAD_0001);
        chk("t1_req_drop", {31'b0, req}, 32'd0);
        ack = 1'b0;

        // Redirect to 0x1004, then 3-cycle memory latency
        npc = 32'h0000_1004; npc_valid = 1'b1;
        exp_req_q.push_back(32'h0000_1004);
        step();
        chk("t2_pc",  pc, 32'h0000_1004);
        chk("t2_req", {31'b0, req}, 32'd1);
        chk("t2_iv",  {31'b0, iv},  32'd0);
        npc_valid = 1'b0;
        data = 32'h1111_2222;
        exp_inst_q.push_back({32'h0000_1004, 32'h1111_2222});
        for (int i = 0; i < 3; i++) begin
            ack = (i == 2);
            chk("t2_addr_stable", addr, 32'h0000_1004);
            chk("t2_req_held", {31'b0, req}, 32'd1);
            step();
        end
        ack = 1'b0;
        chk("t2_iv", {31'b0, iv}, 32'd1);

        // Stall for 4 cycles with npc_valid high
        npc = 32'h0000_1008; npc_valid = 1'b1; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_pc_hold",   pc,   32'h0000_1004);
            chk("t3_inst_hold", inst, 32'h1111_2222);
            chk("t3_iv_hold",   {31'b0, iv},  32'd1);
            chk("t3_no_req",    {31'b0, req}, 32'd0);
        end
        stall = 1'b0;
        exp_req_q.push_back(32'h0000_1008);
        step();
        chk("t3_pc",  pc, 32'h0000_1008);
        chk("t3_req", {31'b0, req}, 32'd1);
        npc_valid = 1'b0;
        ack = 1'b1; data = 32'h3333_4444;
        exp_inst_q.push_back({32'h0000_1008, 32'h3333_4444});
        step();
        ack = 1'b0;
        chk("t3_iv", {31'b0, iv}, 32'd1);

        // Misaligned next PC
        npc = 32'h0000_1006; npc_valid = 1'b1;
        exp_err_q.push_back(32'h0000_1006);
        step();
        npc_valid = 1'b0;
        chk("t4_err", {31'b0, err}, 32'd1);
        chk("t4_pc",  pc, 32'h0000_1006);
        chk("t4_iv",  {31'b0, iv},  32'd0);
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_no_req", {31'b0, req}, 32'd0);
            chk("t4_pc_frozen", pc, 32'h0000_1006);
        end
        ack = 1'b0;

        // Reset during the 2nd wait cycle of a fetch
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        exp_req_q.push_back(RPC);
        step();
        step();
        rst_n = 1'b0; ack = 1'b1;
        step();
        chk("t5_req",  {31'b0, req}, 32'd0);
        chk("t5_iv",   {31'b0, iv},  32'd0);
        chk("t5_err",  {31'b0, err}, 32'd0);
        chk("t5_pc",   pc,   RPC);
        chk("t5_inst", inst, 32'd0);
        rst_n = 1'b1; ack = 1'b0;
        exp_req_q.push_back(RPC);
        step();
        chk("t5_req_again", {31'b0, req}, 32'd1);

        // Timeout with ack never asserted
        hi = 1;
        exp_err_q.push_back(RPC);
        for (int i = 0; i < 12; i++) begin
            step();
            if (req) hi++;
        end
        chk("t6_req_cycles", hi, TO);
        chk("t6_err", {31'b0, err}, 32'd1);
        chk("t6_req", {31'b0, req}, 32'd0);
        ack = 1'b1;
        step(); step();
        chk("t6_late_ack_iv",  {31'b0, iv},  32'd0);
        chk("t6_late_ack_req", {31'b0, req}, 32'd0);
        ack = 1'b0;

        // Ack in the final allowed cycle wins over the timeout
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        exp_req_q.push_back(RPC);
        step();
        data = 32'h5555_6666;
        exp_inst_q.push_back({RPC, 32'h5555_6666});
        for (int i = 0; i < TO; i++) begin
            ack = (i == TO - 1);
            step();
        end
        ack = 1'b0;
        chk("t7_iv",   {31'b0, iv},  32'd1);
        chk("t7_err",  {31'b0, err}, 32'd0);
        chk("t7_inst", inst, 32'h5555_6666);

        step(); step();
        chk("left_req",  exp_req_q.size(),  32'd0);
        chk("left_inst", exp_inst_q.size(), 32'd0);
        chk("left_err",  exp_err_q.size(),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
